// File: rtl/decoder_pkg.sv
// Shared types and constants for the sequential one-hot decoder.
package decoder_pkg;

    localparam int unsigned DEFAULT_N       = 3;
    localparam int unsigned DEFAULT_DWELL_W = 8;

    localparam logic MODE_STREAM = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StStream    = 2'd1,
        StScanEmit  = 2'd2,
        StScanDwell = 2'd3
    } state_e;

endpackage

// File: rtl/decoder_fifo2.sv
// Two-entry FIFO holding stream codes between the producer and consumer handshakes.
module decoder_fifo2
    import decoder_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [N-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [N-1:0] head
);

    logic [N-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    // Requests that would overflow or underflow are dropped.
    assign do_push = push && (count_q != 2'd2);
    assign do_pop  = pop && (count_q != 2'd0);

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; reset discards all buffered entries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/decoder_seq_rtl.sv
// Sequential N-to-2^N one-hot decoder with a stream path through a 2-entry buffer
// and a self-test scan mode that walks every code with a programmable dwell.
module decoder_seq_rtl
    import decoder_pkg::*;
#(
    parameter int unsigned N       = DEFAULT_N,
    parameter int unsigned DWELL_W = DEFAULT_DWELL_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                mode,
    input  logic [DWELL_W-1:0]  dwell,
    input  logic                in_valid,
    input  logic [N-1:0]        in_code,
    output logic                in_ready,
    output logic                out_valid,
    output logic [(1<<N)-1:0]   out_onehot,
    output logic [N-1:0]        out_code,
    input  logic                out_ready,
    output logic                scan_wrap
);

    localparam int unsigned Width = 1 << N;
    localparam logic [N-1:0] LastCode = {N{1'b1}};

    state_e             state_q, state_d;
    logic [N-1:0]       scan_q, scan_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic               drain_q, drain_d;
    logic               scan_wrap_q, scan_wrap_d;

    logic [1:0]         fifo_count;
    logic [N-1:0]       fifo_head;
    logic               push;
    logic               pop;

    assign push = in_valid && in_ready;
    assign pop  = (state_q == StStream) && out_ready && (fifo_count != 2'd0);

    decoder_fifo2 #(
        .N (N)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (in_code),
        .pop       (pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // Next-state logic plus handshake outputs derived from registered state.
    always_comb begin
        state_d     = state_q;
        scan_d      = scan_q;
        dwell_cnt_d = dwell_cnt_q;
        drain_d     = drain_q;
        scan_wrap_d = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_code    = scan_q;

        case (state_q)
            StIdle: begin
                drain_d = 1'b0;
                if (en) begin
                    if (mode == MODE_SCAN) begin
                        state_d = StScanEmit;
                        scan_d  = '0;
                    end else begin
                        state_d = StStream;
                    end
                end
            end

            StStream: begin
                // Once a scan request is seen, stop accepting and drain what is buffered.
                in_ready  = en && (mode == MODE_STREAM) && !drain_q && (fifo_count != 2'd2);
                out_valid = (fifo_count != 2'd0);
                out_code  = fifo_head;
                if (mode == MODE_SCAN) begin
                    drain_d = 1'b1;
                end
                if (drain_q && (fifo_count == 2'd0)) begin
                    state_d = StIdle;
                    drain_d = 1'b0;
                end
            end

            StScanEmit: begin
                // The beat is held until it transfers; en and mode do not retract it.
                out_valid = 1'b1;
                if (out_ready) begin
                    if (scan_q == LastCode) begin
                        scan_wrap_d = 1'b1;
                        scan_d      = '0;
                    end else begin
                        scan_d = scan_q + N'(1);
                    end
                    if (mode == MODE_STREAM) begin
                        state_d = StIdle;
                    end else if (dwell != '0) begin
                        state_d     = StScanDwell;
                        dwell_cnt_d = dwell;
                    end
                end
            end

            StScanDwell: begin
                if (mode == MODE_STREAM) begin
                    state_d     = StIdle;
                    dwell_cnt_d = '0;
                end else if (en) begin
                    if (dwell_cnt_q <= DWELL_W'(1)) begin
                        state_d     = StScanEmit;
                        dwell_cnt_d = '0;
                    end else begin
                        dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, scan code, dwell counter and wrap pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            scan_q      <= '0;
            dwell_cnt_q <= '0;
            drain_q     <= 1'b0;
            scan_wrap_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            scan_q      <= scan_d;
            dwell_cnt_q <= dwell_cnt_d;
            drain_q     <= drain_d;
            scan_wrap_q <= scan_wrap_d;
        end
    end

    assign scan_wrap = scan_wrap_q;

    // One-hot decode of the registered code, gated so idle cycles read all zeros.
    assign out_onehot = out_valid ? ({{(Width-1){1'b0}}, 1'b1} << out_code) : '0;

endmodule

// File: tb/tb_decoder_seq_rtl.sv
// Directed self-checking bench for decoder_seq_rtl at default parameters.
module tb_decoder_seq_rtl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [7:0] dwell;
    logic       in_valid;
    logic [2:0] in_code;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_onehot;
    logic [2:0] out_code;
    logic       out_ready;
    logic       scan_wrap;

    int errors;
    int checks;

    decoder_seq_rtl #(
        .N       (3),
        .DWELL_W (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .dwell      (dwell),
        .in_valid   (in_valid),
        .in_code    (in_code),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_onehot (out_onehot),
        .out_code   (out_code),
        .out_ready  (out_ready),
        .scan_wrap  (scan_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] oh;
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        mode      = 1'b0;
        dwell     = 8'd0;
        in_valid  = 1'b0;
        in_code   = 3'd0;
        out_ready = 1'b0;

        // Reset held 3 cycles with random inputs.
        for (int i = 0; i < 3; i++) begin
            en        = 1'($urandom);
            mode      = 1'($urandom);
            dwell     = 8'($urandom);
            in_valid  = 1'($urandom);
            in_code   = 3'($urandom);
            out_ready = 1'($urandom);
            tick();
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_onehot", out_onehot, 0);
            chk("rst_out_code", out_code, 0);
            chk("rst_scan_wrap", scan_wrap, 0);
        end

        // Release with en low: stays idle.
        rst_n     = 1'b1;
        en        = 1'b0;
        mode      = 1'b0;
        dwell     = 8'd0;
        in_valid  = 1'b0;
        in_code   = 3'd0;
        out_ready = 1'b0;
        tick();
        chk("idle_in_ready", in_ready, 0);
        chk("idle_out_valid", out_valid, 0);
        en = 1'b1;
        chk("en_same_cycle_in_ready", in_ready, 0);
        tick();
        chk("stream_in_ready", in_ready, 1);

        // Stream sweep 0..7 back-to-back.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_code = 3'(k);
            tick();
            oh = 8'h01 << k;
            chk("sweep_valid", out_valid, 1);
            chk("sweep_onehot", out_onehot, oh);
            chk("sweep_code", out_code, k);
            chk("sweep_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("sweep_end_valid", out_valid, 0);
        chk("sweep_end_onehot", out_onehot, 0);

        // Backpressure: push 3, 5, offer 6 while full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 3'd3;
        tick();
        chk("bp_onehot3", out_onehot, 8'h08);
        chk("bp_ready_cnt1", in_ready, 1);
        in_code = 3'd5;
        tick();
        chk("bp_ready_full", in_ready, 0);
        chk("bp_onehot3_hold", out_onehot, 8'h08);
        in_code = 3'd6;
        tick();
        chk("bp_code_hold", out_code, 3);
        chk("bp_ready_full2", in_ready, 0);
        out_ready = 1'b1;
        tick();
        chk("bp_onehot5", out_onehot, 8'h20);
        chk("bp_ready_after_pop", in_ready, 1);
        out_ready = 1'b0;
        tick();
        chk("bp_onehot5_hold", out_onehot, 8'h20);
        chk("bp_ready_full3", in_ready, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_onehot6", out_onehot, 8'h40);
        tick();
        chk("bp_empty", out_valid, 0);

        // Mode switch with two beats buffered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 3'd2;
        tick();
        in_code = 3'd4;
        tick();
        chk("ms_ready_full", in_ready, 0);
        chk("ms_onehot2", out_onehot, 8'h04);
        in_valid = 1'b0;
        mode     = 1'b1;
        dwell    = 8'd2;
        tick();
        chk("ms_code2", out_code, 2);
        chk("ms_ready_drain", in_ready, 0);
        out_ready = 1'b1;
        tick();
        chk("ms_onehot4", out_onehot, 8'h10);
        chk("ms_ready_drain2", in_ready, 0);
        tick();
        chk("ms_drained", out_valid, 0);
        tick();
        chk("ms_idle_valid", out_valid, 0);
        chk("ms_idle_ready", in_ready, 0);
        tick();
        chk("ms_scan0_valid", out_valid, 1);
        chk("ms_scan0_code", out_code, 0);

        // Scan with dwell=2: beats every 3 cycles, wrap after code 7.
        for (int k = 0; k < 8; k++) begin
            oh = 8'h01 << k;
            chk("scan_valid", out_valid, 1);
            chk("scan_code", out_code, k);
            chk("scan_onehot", out_onehot, oh);
            tick();
            chk("scan_gap1_valid", out_valid, 0);
            chk("scan_wrap_gap1", scan_wrap, (k == 7) ? 1 : 0);
            tick();
            chk("scan_gap2_valid", out_valid, 0);
            chk("scan_wrap_gap2", scan_wrap, 0);
            tick();
        end
        chk("scan_repeat_valid", out_valid, 1);
        chk("scan_repeat_code", out_code, 0);
        chk("scan_repeat_onehot", out_onehot, 8'h01);

        // en=0 for 5 cycles during a dwell of 4.
        dwell = 8'd4;
        tick();
        chk("frz_enter_valid", out_valid, 0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("frz_valid", out_valid, 0);
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_count_valid", out_valid, 0);
        end
        tick();
        chk("frz_beat_valid", out_valid, 1);
        chk("frz_beat_code", out_code, 1);

        // Presented beat held under stall with en=0 and mode=0.
        out_ready = 1'b0;
        en        = 1'b0;
        mode      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_onehot", out_onehot, 8'h02);
        end
        out_ready = 1'b1;
        tick();
        chk("hold_exit_valid", out_valid, 0);
        chk("hold_exit_wrap", scan_wrap, 0);

        // Reset with a buffered beat discards it.
        en = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 3'd5;
        tick();
        chk("rmid_valid", out_valid, 1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("rmid_reset_valid", out_valid, 0);
        chk("rmid_reset_ready", in_ready, 0);
        rst_n = 1'b1;
        en    = 1'b0;
        tick();
        chk("rmid_after_valid", out_valid, 0);
        chk("rmid_after_onehot", out_onehot, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
